// File: rtl/rol_seq.sv
// Multi-cycle rotate-left unit: rotates a captured 32-bit operand left by
// RotateBits[4:0], four bits per step while possible, then one bit per step.
module rol_seq (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] Ra,
    input  logic [31:0] RotateBits,
    output logic [31:0] Rz,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] w_q, w_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rz_q, rz_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of order.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            w_q     <= '0;
            cnt_q   <= '0;
            rz_q    <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            rz_q    <= rz_d;
        end
    end

    // NOTE: every signal gets a hold default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        rz_d    = rz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    w_d     = Ra;
                    cnt_d   = RotateBits[4:0];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q >= 5'd4) begin
                    w_d   = {w_q[27:0], w_q[31:28]};
                    cnt_d = cnt_q - 5'd4;
                end else if (cnt_q != 5'd0) begin
                    w_d   = {w_q[30:0], w_q[31]};
                    cnt_d = cnt_q - 5'd1;
                end
                // A zero amount also lands here after its single idle step.
                if (cnt_d == 5'd0) begin
                    rz_d    = w_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        Rz   = rz_q;
    end

endmodule

// File: tb/tb_rol_seq.sv
// Self-checking bench for rol_seq: scoreboard of expected results and step
// counts, scenario tasks run in sequence from one initial block.
module tb_rol_seq;

    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] Ra;
    logic [31:0] RotateBits;
    logic [31:0] Rz;
    logic        busy;
    logic        done;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] rz;
        int          steps;
    } exp_t;

    exp_t sb[$];

    rol_seq dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .Ra         (Ra),
        .RotateBits (RotateBits),
        .Rz         (Rz),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] rol_model(input logic [31:0] a, input logic [4:0] n);
        if (n == 5'd0) return a;
        return (a << n) | (a >> (6'd32 - {1'b0, n}));
    endfunction

    function automatic int steps_model(input logic [4:0] n);
        int ni;
        ni = int'(n);
        if (ni == 0) return 1;
        return (ni / 4) + (ni % 4);
    endfunction

    // Issue one operation from a sync point (posedge+1) and wait for done.
    // Leaves the bench at the sync point one edge after the done cycle.
    task automatic run_op(input logic [31:0] ra, input logic [31:0] amt,
                          output logic [31:0] rz, output int lat, output int busy_n,
                          output logic done_after, output logic busy_after,
                          output bit timeout);
        exp_t e;
        e.rz    = rol_model(ra, amt[4:0]);
        e.steps = steps_model(amt[4:0]);
        sb.push_back(e);
        start = 1'b1;
        Ra = ra;
        RotateBits = amt;
        @(posedge clock); #1;
        start = 1'b0;
        Ra = $urandom;
        RotateBits = $urandom;
        lat = 0;
        busy_n = (busy === 1'b1) ? 1 : 0;
        timeout = 0;
        while (done !== 1'b1 && !timeout) begin
            @(posedge clock); #1;
            lat++;
            if (busy === 1'b1) busy_n++;
            if (lat > 40) timeout = 1;
        end
        rz = Rz;
        @(posedge clock); #1;
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset;
        clear = 1'b0;
        start = 1'b1;
        Ra = 32'h0000_000F;
        RotateBits = 32'd4;
        #11;
        tests_run++;
        if (Rz !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: Rz=%h busy=%b done=%b, need Rz=0 busy=0 done=0", Rz, busy, done);
        end
        #1 clear = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_accept: busy=%b after first edge, need 1", busy);
        end
        begin
            int lat = 0;
            while (done !== 1'b1 && lat <= 40) begin
                @(posedge clock); #1;
                lat++;
            end
            tests_run++;
            if (Rz !== 32'h0000_00F0 || lat != 1) begin
                tests_failed++;
                $display("FAIL first_op: Rz=%h lat=%0d, need Rz=000000f0 lat=1", Rz, lat);
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_rotate_basic;
        logic [31:0] ras[5]  = '{32'h8000_0001, 32'h8000_0001, 32'h1234_5678, 32'h1234_5678, 32'hDEAD_BEEF};
        logic [31:0] amts[5] = '{32'd1, 32'd31, 32'h0000_0024, 32'd13, 32'd0};
        for (int i = 0; i < 5; i++) begin
            logic [31:0] rz;
            int lat, busy_n;
            logic da, ba;
            bit to;
            exp_t e;
            run_op(ras[i], amts[i], rz, lat, busy_n, da, ba, to);
            e = sb.pop_front();
            tests_run++;
            if (to || rz !== e.rz) begin
                tests_failed++;
                $display("FAIL basic_rz[%0d]: Rz=%h, need %h (timeout=%0d)", i, rz, e.rz, to);
            end
            tests_run++;
            if (lat != e.steps) begin
                tests_failed++;
                $display("FAIL basic_latency[%0d]: %0d steps, need %0d", i, lat, e.steps);
            end
            tests_run++;
            if (busy_n != e.steps + 1) begin
                tests_failed++;
                $display("FAIL basic_busy[%0d]: busy high %0d cycles, need %0d", i, busy_n, e.steps + 1);
            end
            tests_run++;
            if (da !== 1'b0 || ba !== 1'b0) begin
                tests_failed++;
                $display("FAIL basic_after[%0d]: done=%b busy=%b after done cycle, need 0 0", i, da, ba);
            end
        end
    endtask

    task automatic test_ignore_start;
        exp_t e;
        int lat = 0;
        e.rz = rol_model(32'h0F0F_1234, 5'd31);
        e.steps = steps_model(5'd31);
        sb.push_back(e);
        start = 1'b1;
        Ra = 32'h0F0F_1234;
        RotateBits = 32'd31;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
            lat++;
        end
        start = 1'b1;
        Ra = 32'hFFFF_0000;
        RotateBits = 32'd1;
        @(posedge clock); #1;
        lat++;
        start = 1'b0;
        while (done !== 1'b1 && lat <= 40) begin
            @(posedge clock); #1;
            lat++;
        end
        start = 1'b1;
        Ra = 32'hFFFF_0000;
        RotateBits = 32'd1;
        @(posedge clock); #1;
        start = 1'b0;
        e = sb.pop_front();
        tests_run++;
        if (Rz !== e.rz || lat != e.steps) begin
            tests_failed++;
            $display("FAIL ignore_rz: Rz=%h lat=%0d, need %h lat=%0d", Rz, lat, e.rz, e.steps);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_done_start: busy=%b after start in DONE, need 0", busy);
        end
        @(posedge clock); #1;
        tests_run++;
        if (busy !== 1'b0 || Rz !== e.rz) begin
            tests_failed++;
            $display("FAIL ignore_idle: busy=%b Rz=%h, need 0 %h", busy, Rz, e.rz);
        end
    endtask

    task automatic test_back_to_back;
        int done_at[$];
        int s;
        logic [31:0] exp_rz;
        s = steps_model(5'd5);
        exp_rz = rol_model(32'h0000_0001, 5'd5);
        start = 1'b1;
        Ra = 32'h0000_0001;
        RotateBits = 32'd5;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock); #1;
            if (done === 1'b1) done_at.push_back(c);
        end
        start = 1'b0;
        tests_run++;
        if (done_at.size() != 5) begin
            tests_failed++;
            $display("FAIL b2b_count: %0d done pulses, need 5", done_at.size());
        end
        for (int k = 0; k < done_at.size(); k++) begin
            tests_run++;
            if (done_at[k] != 1 + s + k * (s + 2)) begin
                tests_failed++;
                $display("FAIL b2b_spacing[%0d]: done at cycle %0d, need %0d", k, done_at[k], 1 + s + k * (s + 2));
            end
        end
        tests_run++;
        if (Rz !== exp_rz) begin
            tests_failed++;
            $display("FAIL b2b_rz: Rz=%h, need %h", Rz, exp_rz);
        end
        for (int c = 0; c < 12 && busy === 1'b1; c++) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic test_abort;
        bit saw_done = 0;
        logic [31:0] rz;
        int lat, busy_n;
        logic da, ba;
        bit to;
        exp_t e;
        start = 1'b1;
        Ra = 32'h8000_0001;
        RotateBits = 32'd31;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #3 clear = 1'b0;
        #1;
        tests_run++;
        if (Rz !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_state: Rz=%h busy=%b done=%b, need 0 0 0", Rz, busy, done);
        end
        #2 clear = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clock); #1;
            if (done === 1'b1) saw_done = 1;
        end
        tests_run++;
        if (saw_done || Rz !== 32'h0) begin
            tests_failed++;
            $display("FAIL abort_no_done: saw_done=%0d Rz=%h, need 0 and 00000000", saw_done, Rz);
        end
        run_op(32'h0000_000F, 32'd4, rz, lat, busy_n, da, ba, to);
        e = sb.pop_front();
        tests_run++;
        if (to || rz !== 32'h0000_00F0 || lat != 1) begin
            tests_failed++;
            $display("FAIL abort_recover: Rz=%h lat=%0d, need 000000f0 lat=1 (expect %h)", rz, lat, e.rz);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] rz, ra, amt;
            int lat, busy_n;
            logic da, ba;
            bit to;
            exp_t e;
            ra = $urandom;
            amt = $urandom;
            run_op(ra, amt, rz, lat, busy_n, da, ba, to);
            e = sb.pop_front();
            tests_run++;
            if (to || rz !== e.rz || lat != e.steps) begin
                tests_failed++;
                $display("FAIL random[%0d]: Ra=%h n=%0d Rz=%h lat=%0d, need %h lat=%0d",
                         i, ra, amt[4:0], rz, lat, e.rz, e.steps);
            end
        end
    endtask

    initial begin
        start = 1'b0;
        Ra = '0;
        RotateBits = '0;
        test_reset();
        test_rotate_basic();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
